gf_mul_scheduler: RTL and testbench
===================================

// Module: gf_mul_scheduler
// PURPOSE
//  Shares one pipelined 51x51 multiplier instance (mnozenie) between up to N_REQ requesters, e.g. minor, determinant, inversion.
//  Per-cycle round-robin grant; operands are registered into the multiplier and a tag pipeline tracks each product.
//  Each product is returned to its originator with fixed latency. Replaces per-block multiplier copies and ad-hoc delay counters.
// PARAMETERS
//  N_REQ    4   number of requesters (2..8)
//  DATA_W   51  operand width; product is 2*DATA_W
//  MUL_LAT  11  cycles from mul_a/mul_b register to valid mul_result (>=1)
// PORTS
//  clk        in   1               clock
//  rst        in   1               reset, asynchronous, active-high
//  sched_en   in   1               0 = issue no new grants; in-flight products still complete
//  req        in   N_REQ           per-requester request level
//  req_a      in   N_REQ x DATA_W  operand A, held stable while req=1 and gnt=0
//  req_b      in   N_REQ x DATA_W  operand B, same rule as req_a
//  gnt        out  N_REQ           one-hot grant pulse, combinational; operands accepted this cycle
//  mul_a      out  DATA_W          registered operand to the multiplier dataa_0
//  mul_b      out  DATA_W          registered operand to the multiplier datab_0
//  mul_result in   2*DATA_W        multiplier result
//  res_valid  out  N_REQ           one-hot pulse: product for that requester on res_data
//  res_data   out  2*DATA_W        product, registered
//  busy       out  1               1 while any product is in flight
// BEHAVIOUR
//  Reset: gnt=0, mul_a=0, mul_b=0, res_valid=0, res_data=0, busy=0, tag pipe cleared, rr_ptr=N_REQ-1.
//  Arbitration: when sched_en=1, grant the first req bit searching from rr_ptr+1 (mod N_REQ) upward.
//   - At most one grant per cycle.
//   - On a grant, rr_ptr takes the granted index at the edge; otherwise rr_ptr holds.
//  Accept: in grant cycle t, req_a/req_b of the winner load into mul_a/mul_b at edge t.
//   - The tag {vld=1, id} enters stage 0 of a MUL_LAT-deep shift register.
//   - Without a grant, mul_a/mul_b hold and tag vld=0 enters.
//  Return: a granted product produces res_valid[id]=1 for exactly one cycle at cycle t+MUL_LAT+1.
//   - res_data=mul_result is registered at the same edge.
//   - Throughput is one product per cycle; back-to-back grants return back-to-back.
//  res_data holds its last value when res_valid=0.
//  Requester rule: a requester drops req or changes operands only after seeing its gnt. A new req in the cycle after gnt is legal.
//  busy = OR of all tag vld bits plus any product whose res_valid is pending.
//  Boundaries:
//   - req deasserted before gnt: the request is withdrawn and no result is produced.
//   - sched_en falling in a cycle blocks the grant in that same cycle.
//   - Reset mid-flight: all tags are dropped and no res_valid is issued. Requesters must reissue.
//   - A single requester asserting continuously is granted every cycle.
//   - N_REQ=1: the arbiter degenerates to req&sched_en.
//  No reduction modulo the field polynomial; the consumer reduces.
// CONFIGURATION
//  GF_MUL_SCHED_STATS_EN
//   - Defined: adds output stat_grants[N_REQ][15:0], a saturating per-requester grant count, and stat_stall[15:0].
//   - stat_stall is a saturating count of cycles where req!=0 but gnt=0.
//   - All counters are cleared by rst.
//   - Undefined: these ports and counters do not exist.
// STRUCTURE
//  Package bch_mul_pkg: DATA_W, N_REQ, ID_W=$clog2(N_REQ) constants; typedef mul_tag_t {logic vld; logic [ID_W-1:0] id;}.
//  Sub-module rr_arbiter: purely combinational; inputs req, en, ptr; output one-hot gnt. Pointer register stays in gf_mul_scheduler.
//  The mnozenie instance stays outside; the bench uses a behavioural MUL_LAT-deep pipelined multiplier.
// TESTING
//  1. Single req[0], a=3, b=5, sched_en=1 -> gnt[0] in cycle 0; res_valid=0001, res_data=15 at cycle MUL_LAT+1; busy falls next cycle.
//  2. req=1111 held 8 cycles, constant operands -> grant order 0,1,2,3,0,1,2,3 with no idle cycles; results return in the same order.
//  3. req=0101 with rr_ptr=0 -> gnt[2] first, then gnt[0]; no starvation.
//  4. sched_en=0 with req=0011 for 5 cycles -> gnt=0 throughout; in-flight product still returns; granting resumes at rr_ptr+1 when re-enabled.
//  5. rst pulse at cycle 4 after 3 grants -> no res_valid ever; all outputs 0; rr_ptr=N_REQ-1.
//  6. With GF_MUL_SCHED_STATS_EN, 10 grants to req[1] and 4 stall cycles -> stat_grants[1]=10, stat_stall=4.

Source files
------------

// File: rtl/bch_mul_pkg.sv
// Shared constants and types for the GF(2^m) multiplier scheduler slice.
package bch_mul_pkg;

    localparam int N_REQ   = 4;
    localparam int DATA_W  = 51;
    localparam int MUL_LAT = 11;
    localparam int ID_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    // Tag carried alongside each product through the multiplier latency.
    typedef struct packed {
        logic            vld;
        logic [ID_W-1:0] id;
    } mul_tag_t;

    // Encode a one-hot (or all-zero) vector into a requester index.
    function automatic logic [ID_W-1:0] onehot_to_id(input logic [N_REQ-1:0] oh);
        logic [ID_W-1:0] id;
        id = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (oh[i]) id = id | ID_W'(i);
        end
        return id;
    endfunction

endpackage

// File: rtl/gf_mul_scheduler_if.sv
// Requester, multiplier and return-path signals of the multiplier scheduler.
interface gf_mul_scheduler_if;
    import bch_mul_pkg::*;

    logic                          sched_en;
    logic [N_REQ-1:0]              req;
    logic [N_REQ-1:0][DATA_W-1:0]  req_a;
    logic [N_REQ-1:0][DATA_W-1:0]  req_b;
    logic [N_REQ-1:0]              gnt;
    logic [DATA_W-1:0]             mul_a;
    logic [DATA_W-1:0]             mul_b;
    logic [2*DATA_W-1:0]           mul_result;
    logic [N_REQ-1:0]              res_valid;
    logic [2*DATA_W-1:0]           res_data;
    logic                          busy;

    // Scheduler side.
    modport slave (
        input  sched_en, req, req_a, req_b, mul_result,
        output gnt, mul_a, mul_b, res_valid, res_data, busy
    );

    // Requesters plus external multiplier side.
    modport master (
        output sched_en, req, req_a, req_b, mul_result,
        input  gnt, mul_a, mul_b, res_valid, res_data, busy
    );

endinterface

// File: rtl/gf_mul_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first request above ptr wins, one-hot grant.
module rr_arbiter
    import bch_mul_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic             en,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] gnt
);

    logic found;
    int   idx;

    // Scan from ptr+1 upward (wrapping) and grant the first asserted request.
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 1; i <= N_REQ; i++) begin
            idx = (int'(ptr) + i) % N_REQ;
            if (en && !found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/gf_mul_scheduler.sv
// Shares one external pipelined multiplier between N_REQ requesters.
// Round-robin grant per cycle, operands registered toward the multiplier,
// a tag pipeline returns each product to its requester MUL_LAT+1 cycles
// after its grant. Optional statistics counters under GF_MUL_SCHED_STATS_EN.
module gf_mul_scheduler
    import bch_mul_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    gf_mul_scheduler_if.slave   bus
`ifdef GF_MUL_SCHED_STATS_EN
    ,
    output logic [N_REQ-1:0][15:0] stat_grants,
    output logic [15:0]            stat_stall
`endif
);

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [ID_W-1:0]     rr_ptr;
    logic [N_REQ-1:0]    gnt;
    logic                gnt_any;
    logic [ID_W-1:0]     gnt_id;
    logic                arb_en;
    mul_tag_t            tag_pipe [MUL_LAT];
    mul_tag_t            tag_out;
    logic [DATA_W-1:0]   mul_a_p0;
    logic [DATA_W-1:0]   mul_b_p0;
    logic [N_REQ-1:0]    res_valid_p1;
    logic [2*DATA_W-1:0] res_data_p1;
    logic                busy;

    // No grant may be issued while reset is held.
    assign arb_en = bus.sched_en & ~rst;

    rr_arbiter u_arb (
        .req (bus.req),
        .en  (arb_en),
        .ptr (rr_ptr),
        .gnt (gnt)
    );

    assign gnt_any = |gnt;
    assign gnt_id  = onehot_to_id(gnt);
    assign tag_out = tag_pipe[MUL_LAT-1];

    // Round-robin pointer follows the most recent winner.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)          rr_ptr <= ID_W'(N_REQ - 1);
        else if (gnt_any) rr_ptr <= gnt_id;
    end

    // Stage p0: capture the winner's operands for the multiplier.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mul_a_p0 <= '0;
            mul_b_p0 <= '0;
        end else if (gnt_any) begin
            mul_a_p0 <= bus.req_a[gnt_id];
            mul_b_p0 <= bus.req_b[gnt_id];
        end
    end

    // Tag pipeline mirrors the multiplier latency so each product keeps its owner.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < MUL_LAT; k++) tag_pipe[k] <= '0;
        end else begin
            tag_pipe[0] <= '{vld: gnt_any, id: gnt_id};
            for (int k = 1; k < MUL_LAT; k++) tag_pipe[k] <= tag_pipe[k-1];
        end
    end

    // Stage p1: register the product and pulse the owner's valid bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_valid_p1 <= '0;
            res_data_p1  <= '0;
        end else begin
            res_valid_p1 <= tag_out.vld ? (N_REQ'(1) << tag_out.id) : '0;
            if (tag_out.vld) res_data_p1 <= bus.mul_result;
        end
    end

    // Busy while any tag is in flight or a result is being presented.
    always_comb begin
        busy = |res_valid_p1;
        for (int k = 0; k < MUL_LAT; k++) busy = busy | tag_pipe[k].vld;
    end

`ifdef GF_MUL_SCHED_STATS_EN
    // Saturating per-requester grant counts and stalled-request cycle count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_grants <= '0;
            stat_stall  <= '0;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (gnt[i]) stat_grants[i] <= sat_inc16(stat_grants[i]);
            end
            if ((|bus.req) && !gnt_any) stat_stall <= sat_inc16(stat_stall);
        end
    end
`endif

    assign bus.gnt       = gnt;
    assign bus.mul_a     = mul_a_p0;
    assign bus.mul_b     = mul_b_p0;
    assign bus.res_valid = res_valid_p1;
    assign bus.res_data  = res_data_p1;
    assign bus.busy      = busy;

endmodule

// File: tb/tb_gf_mul_scheduler.sv
// Directed bench for gf_mul_scheduler with a behavioural pipelined multiplier.
module tb_gf_mul_scheduler;
    import bch_mul_pkg::*;

    typedef struct packed {
        logic [N_REQ-1:0] req;
        logic             en;
        logic [N_REQ-1:0] exp_gnt;
    } vec_t;

    typedef struct packed {
        logic [31:0]         due;
        logic [31:0]         id;
        logic [2*DATA_W-1:0] data;
    } exp_t;

    localparam int NV = 27;

    logic clk;
    logic rst;
    int   cyc;
    int   n_chk;
    int   n_fail;
    int   g_cyc;
    logic mon_en;

    logic [DATA_W-1:0]   op_a [N_REQ];
    logic [DATA_W-1:0]   op_b [N_REQ];
    logic [2*DATA_W-1:0] mpipe [MUL_LAT-1];
    exp_t                exp_q [$];
    vec_t                tbl [NV];

    gf_mul_scheduler_if bus();

`ifdef GF_MUL_SCHED_STATS_EN
    logic [N_REQ-1:0][15:0] stat_grants;
    logic [15:0]            stat_stall;
`endif

    gf_mul_scheduler dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef GF_MUL_SCHED_STATS_EN
        ,
        .stat_grants (stat_grants),
        .stat_stall  (stat_stall)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural multiplier: the scheduler's operand register plus MUL_LAT-1 stages.
    always @(posedge clk) begin
        mpipe[0] <= (2*DATA_W)'(bus.mul_a) * (2*DATA_W)'(bus.mul_b);
        for (int k = 1; k < MUL_LAT - 1; k++) mpipe[k] <= mpipe[k-1];
    end
    assign bus.mul_result = mpipe[MUL_LAT-2];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Return-path scoreboard: every cycle res_valid must match the expected queue.
    always @(negedge clk) begin
        if (mon_en) begin
            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                chk($sformatf("res_valid cyc %0d", cyc), 128'(bus.res_valid),
                    128'(N_REQ'(1) << exp_q[0].id));
                chk($sformatf("res_data cyc %0d", cyc), 128'(bus.res_data), 128'(exp_q[0].data));
                void'(exp_q.pop_front());
            end else begin
                chk($sformatf("res_valid idle cyc %0d", cyc), 128'(bus.res_valid), 128'(0));
            end
        end
    end

    task automatic step(input logic [N_REQ-1:0] r, input logic en,
                        input logic [N_REQ-1:0] eg, input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        bus.req      = r;
        bus.sched_en = en;
        for (int i = 0; i < N_REQ; i++) begin
            bus.req_a[i] = op_a[i];
            bus.req_b[i] = op_b[i];
        end
        @(negedge clk);
        chk({"gnt ", nm}, 128'(bus.gnt), 128'(eg));
        g_cyc = cyc;
        for (int i = 0; i < N_REQ; i++) begin
            if (eg[i]) begin
                e.due  = 32'(cyc + MUL_LAT + 1);
                e.id   = 32'(i);
                e.data = (2*DATA_W)'(op_a[i]) * (2*DATA_W)'(op_b[i]);
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, " gnt"},       128'(bus.gnt),       128'(0));
        chk({nm, " mul_a"},     128'(bus.mul_a),     128'(0));
        chk({nm, " mul_b"},     128'(bus.mul_b),     128'(0));
        chk({nm, " res_valid"}, 128'(bus.res_valid), 128'(0));
        chk({nm, " res_data"},  128'(bus.res_data),  128'(0));
        chk({nm, " busy"},      128'(bus.busy),      128'(0));
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        cyc    = 0;
        mon_en = 1'b0;
        rst    = 1'b1;
        bus.req      = '0;
        bus.sched_en = 1'b0;
        bus.req_a    = '0;
        bus.req_b    = '0;
        for (int i = 0; i < N_REQ; i++) begin
            op_a[i] = '0;
            op_b[i] = '0;
        end

        tbl[0]  = '{4'b0101, 1'b1, 4'b0100};
        tbl[1]  = '{4'b0101, 1'b1, 4'b0001};
        tbl[2]  = '{4'b1000, 1'b1, 4'b1000};
        tbl[3]  = '{4'b1111, 1'b1, 4'b0001};
        tbl[4]  = '{4'b1111, 1'b1, 4'b0010};
        tbl[5]  = '{4'b1111, 1'b1, 4'b0100};
        tbl[6]  = '{4'b1111, 1'b1, 4'b1000};
        tbl[7]  = '{4'b1111, 1'b1, 4'b0001};
        tbl[8]  = '{4'b1111, 1'b1, 4'b0010};
        tbl[9]  = '{4'b1111, 1'b1, 4'b0100};
        tbl[10] = '{4'b1111, 1'b1, 4'b1000};
        tbl[11] = '{4'b0011, 1'b0, 4'b0000};
        tbl[12] = '{4'b0011, 1'b0, 4'b0000};
        tbl[13] = '{4'b0011, 1'b0, 4'b0000};
        tbl[14] = '{4'b0011, 1'b0, 4'b0000};
        tbl[15] = '{4'b0011, 1'b0, 4'b0000};
        tbl[16] = '{4'b0011, 1'b1, 4'b0001};
        tbl[17] = '{4'b0011, 1'b1, 4'b0010};
        tbl[18] = '{4'b0000, 1'b1, 4'b0000};
        tbl[19] = '{4'b0010, 1'b1, 4'b0010};
        tbl[20] = '{4'b0010, 1'b1, 4'b0010};
        tbl[21] = '{4'b0010, 1'b1, 4'b0010};
        tbl[22] = '{4'b0010, 1'b0, 4'b0000};
        tbl[23] = '{4'b0100, 1'b0, 4'b0000};
        tbl[24] = '{4'b0000, 1'b1, 4'b0000};
        tbl[25] = '{4'b1001, 1'b1, 4'b1000};
        tbl[26] = '{4'b1001, 1'b1, 4'b0001};

        // Reset state, including a request that must not be granted under reset.
        repeat (2) @(posedge clk);
        #1;
        bus.req      = 4'b0001;
        bus.sched_en = 1'b1;
        #1;
        chk_all_zero("reset");
        bus.req = '0;
        #1;
        rst = 1'b0;
        mon_en = 1'b1;

        // Single request: 3*5 returns MUL_LAT+1 cycles after the grant.
        op_a[0] = 51'd3;
        op_b[0] = 51'd5;
        step(4'b0001, 1'b1, 4'b0001, "single");
        step(4'b0000, 1'b1, 4'b0000, "single idle");
        chk("single mul_a", 128'(bus.mul_a), 128'(3));
        chk("single mul_b", 128'(bus.mul_b), 128'(5));
        chk("single busy in flight", 128'(bus.busy), 128'(1));
        for (int k = 0; k < MUL_LAT; k++) step(4'b0000, 1'b1, 4'b0000, "single wait");
        chk("single res_valid", 128'(bus.res_valid), 128'(4'b0001));
        chk("single res_data", 128'(bus.res_data), 128'(15));
        chk("single busy at return", 128'(bus.busy), 128'(1));
        step(4'b0000, 1'b1, 4'b0000, "single after");
        chk("single busy falls", 128'(bus.busy), 128'(0));
        chk("single res_data holds", 128'(bus.res_data), 128'(15));

        // Arbitration table with wide operands.
        op_a[0] = 51'h7_FFFF_FFFF_FFFF; op_b[0] = 51'h7_FFFF_FFFF_FFFF;
        op_a[1] = 51'd1000;             op_b[1] = 51'd123456789;
        op_a[2] = 51'h4_0000_0000_0000; op_b[2] = 51'd3;
        op_a[3] = 51'd7;                op_b[3] = 51'h5_5555_5555_5555;
        for (int v = 0; v < NV; v++)
            step(tbl[v].req, tbl[v].en, tbl[v].exp_gnt, $sformatf("row %0d", v));

        // Reset mid-flight after three grants: nothing may return.
        step(4'b0111, 1'b1, 4'b0010, "pre-rst 0");
        step(4'b0111, 1'b1, 4'b0100, "pre-rst 1");
        step(4'b0111, 1'b1, 4'b0001, "pre-rst 2");
        step(4'b0000, 1'b1, 4'b0000, "pre-rst 3");
        @(posedge clk);
        #1;
        bus.req = '0;
        #1;
        rst = 1'b1;
        exp_q.delete();
        #1;
        chk_all_zero("midrst");
        #1;
        rst = 1'b0;
        for (int k = 0; k < MUL_LAT + 3; k++) step(4'b0000, 1'b1, 4'b0000, "post-rst idle");
        chk_all_zero("post-rst");
        step(4'b0011, 1'b1, 4'b0001, "ptr after rst");

        // Continuous single requester and stall cycles.
        for (int k = 0; k < 10; k++) step(4'b0010, 1'b1, 4'b0010, "continuous");
        for (int k = 0; k < 4; k++) step(4'b0010, 1'b0, 4'b0000, "stalled");
        step(4'b0000, 1'b1, 4'b0000, "stats end");
`ifdef GF_MUL_SCHED_STATS_EN
        chk("stat_grants[0]", 128'(stat_grants[0]), 128'(1));
        chk("stat_grants[1]", 128'(stat_grants[1]), 128'(10));
        chk("stat_grants[2]", 128'(stat_grants[2]), 128'(0));
        chk("stat_grants[3]", 128'(stat_grants[3]), 128'(0));
        chk("stat_stall", 128'(stat_stall), 128'(4));
`endif

        // Drain: every expected product must have come back.
        for (int k = 0; k < MUL_LAT + 3; k++) step(4'b0000, 1'b1, 4'b0000, "drain");
        chk("pending results", 128'(exp_q.size()), 128'(0));
        chk("final busy", 128'(bus.busy), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
